// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_port_arbiter_pkg;

  // Owner of a read in flight.
  localparam logic OWN_HOST = 1'b0;
  localparam logic OWN_ENG  = 1'b1;

  // Arbiter state: which requester owns the SRAM command this cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_H = 2'b01,
    GNT_E = 2'b10
  } state_e;

  // Read-return tag carried alongside the SRAM read latency.
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/sram_port_arbiter_rd_tag_pipe.sv
// RD_LAT-stage shift register of read tags; the last stage lines up with sram_rdata.
module sram_port_arbiter_rd_tag_pipe
  import sram_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    any_valid
);

  rd_tag_t stage [RD_LAT];

  // Shift tags one stage per cycle; reset discards reads in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  // Any read still waiting for its data.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < RD_LAT; i++) any_valid = any_valid | stage[i].valid;
  end

  assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between the host loader and the adder engine.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int MAX_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              e_req,
  input  logic [ADDR_W-1:0] e_addr,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  output logic              SRAM_re,
  output logic              SRAM_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  localparam logic [3:0] MaxRun = 4'(MAX_RUN);

  state_e            state_q, state_d;
  logic [3:0]        run_cnt_q, run_cnt_d;
  logic              re_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] h_rdata_q, e_rdata_q;
  rd_tag_t           tag_in, tag_out;
  logic              tags_busy;

  // Grant decision and host-run counter; host wins unless it has starved the engine.
  always_comb begin
    state_d = IDLE;
    if (h_req && e_req) begin
      state_d = (run_cnt_q < MaxRun) ? GNT_H : GNT_E;
    end else if (h_req) begin
      state_d = GNT_H;
    end else if (e_req) begin
      state_d = GNT_E;
    end

    run_cnt_d = run_cnt_q;
    if (!e_req || state_d == GNT_E) begin
      run_cnt_d = '0;
    end else if (state_d == GNT_H) begin
      run_cnt_d = run_cnt_q + 4'd1;
    end
  end

  // State and run counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Registered SRAM command, captured from the winning requester at the decision edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_d)
        GNT_H: begin
          re_q    <= ~h_we;
          we_q    <= h_we;
          addr_q  <= h_addr;
          wdata_q <= h_wdata;
        end
        GNT_E: begin
          re_q    <= 1'b1;
          we_q    <= 1'b0;
          addr_q  <= e_addr;
          wdata_q <= '0;
        end
        default: begin
          // Address and data hold so the SRAM pins stay quiet when idle.
          re_q <= 1'b0;
          we_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag enters the pipe as the read command is presented to the SRAM.
  assign tag_in.valid = re_q;
  assign tag_in.owner = (state_q == GNT_E) ? OWN_ENG : OWN_HOST;

  sram_port_arbiter_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .any_valid (tags_busy)
  );

  assign h_rvalid = tag_out.valid && (tag_out.owner == OWN_HOST);
  assign e_rvalid = tag_out.valid && (tag_out.owner == OWN_ENG);

  // Last delivered read data per requester, held between returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_rdata_q <= '0;
      e_rdata_q <= '0;
    end else begin
      if (h_rvalid) h_rdata_q <= sram_rdata;
      if (e_rvalid) e_rdata_q <= sram_rdata;
    end
  end

  assign h_rdata    = h_rvalid ? sram_rdata : h_rdata_q;
  assign e_rdata    = e_rvalid ? sram_rdata : e_rdata_q;
  assign h_gnt      = (state_q == GNT_H);
  assign e_gnt      = (state_q == GNT_E);
  assign SRAM_re    = re_q;
  assign SRAM_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  // The command stage counts as in flight so busy has no gap before the tag enters the pipe.
  assign busy       = ~reset & (h_req | e_req | re_q | tags_busy);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench: three arbiters (RD_LAT 1..3) share stimulus and are checked against a queue model.
module tb_sram_port_arbiter;

  localparam int MAX_RUN = 4;
  localparam int NL      = 3;

  typedef struct {
    int         cyc;
    bit         own;
    logic [7:0] data;
  } rd_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_clr;
  logic       h_req, h_we, e_req;
  logic [7:0] h_addr, h_wdata, e_addr;

  logic       h_gnt_w [NL];
  logic       h_rvalid_w [NL];
  logic [7:0] h_rdata_w [NL];
  logic       e_gnt_w [NL];
  logic       e_rvalid_w [NL];
  logic [7:0] e_rdata_w [NL];
  logic       re_w [NL];
  logic       we_w [NL];
  logic [7:0] addr_w [NL];
  logic [7:0] wdata_w [NL];
  logic [7:0] rdata_w [NL];
  logic       busy_w [NL];

  always #5 clk = ~clk;

  for (genvar l = 0; l < NL; l++) begin : g_lane
    logic [7:0] smem [256];
    logic [7:0] spipe [l+1];

    sram_port_arbiter #(
      .ADDR_W  (8),
      .DATA_W  (8),
      .RD_LAT  (l + 1),
      .MAX_RUN (MAX_RUN)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .h_req      (h_req),
      .h_we       (h_we),
      .h_addr     (h_addr),
      .h_wdata    (h_wdata),
      .h_gnt      (h_gnt_w[l]),
      .h_rvalid   (h_rvalid_w[l]),
      .h_rdata    (h_rdata_w[l]),
      .e_req      (e_req),
      .e_addr     (e_addr),
      .e_gnt      (e_gnt_w[l]),
      .e_rvalid   (e_rvalid_w[l]),
      .e_rdata    (e_rdata_w[l]),
      .SRAM_re    (re_w[l]),
      .SRAM_we    (we_w[l]),
      .sram_addr  (addr_w[l]),
      .sram_wdata (wdata_w[l]),
      .sram_rdata (rdata_w[l]),
      .busy       (busy_w[l])
    );

    // Synchronous SRAM with l+1 cycles from command to data.
    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 256; i++) smem[i] <= 8'h00;
        for (int k = 0; k <= l; k++) spipe[k] <= 8'h00;
      end else begin
        if (we_w[l]) smem[addr_w[l]] <= wdata_w[l];
        spipe[0] <= re_w[l] ? smem[addr_w[l]] : 8'h00;
        for (int k = 1; k <= l; k++) spipe[k] <= spipe[k-1];
      end
    end
    assign rdata_w[l] = spipe[l];
  end

  // Reference model state.
  int         n_chk, n_fail;
  int         cyc;
  int         mg;            // 0 none, 1 host, 2 engine granted this cycle
  int         run;
  logic       x_re, x_we;
  logic [7:0] x_addr, x_wdata;
  logic [7:0] mmem [256];
  rd_t        q[$];
  logic [7:0] x_hrd [NL];
  logic [7:0] x_erd [NL];

  task automatic chk(string tag, int l, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lane%0d observed=%0h expected=%0h", tag, l, obs, exp);
    end
  endtask

  task automatic model_reset();
    mg = 0; run = 0;
    x_re = 1'b0; x_we = 1'b0; x_addr = 8'h00; x_wdata = 8'h00;
    q.delete();
    for (int l = 0; l < NL; l++) begin
      x_hrd[l] = 8'h00;
      x_erd[l] = 8'h00;
    end
  endtask

  // Apply the arbitration rules to the inputs present at this edge.
  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    mg = 0;
    if (h_req && e_req) mg = (run < MAX_RUN) ? 1 : 2;
    else if (h_req) mg = 1;
    else if (e_req) mg = 2;
    if (!e_req || mg == 2) run = 0;
    else if (mg == 1) run++;
    while (q.size() > 0 && q[0].cyc + NL < cyc) void'(q.pop_front());
    if (mg == 1) begin
      x_re = !h_we; x_we = h_we; x_addr = h_addr; x_wdata = h_wdata;
      if (h_we) mmem[h_addr] = h_wdata;
      else q.push_back('{cyc: cyc, own: 1'b0, data: mmem[h_addr]});
    end else if (mg == 2) begin
      x_re = 1'b1; x_we = 1'b0; x_addr = e_addr; x_wdata = 8'h00;
      q.push_back('{cyc: cyc, own: 1'b1, data: mmem[e_addr]});
    end else begin
      x_re = 1'b0; x_we = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int l = 0; l < NL; l++) begin
      int   lat;
      logic hv, ev, fl, bz;
      lat = l + 1; hv = 1'b0; ev = 1'b0; fl = 1'b0;
      foreach (q[i]) begin
        if (q[i].cyc + lat == cyc) begin
          if (q[i].own) begin ev = 1'b1; x_erd[l] = q[i].data; end
          else begin hv = 1'b1; x_hrd[l] = q[i].data; end
        end
        if (q[i].cyc <= cyc && cyc <= q[i].cyc + lat) fl = 1'b1;
      end
      bz = !reset && (h_req || e_req || fl);
      chk("h_gnt", l, h_gnt_w[l], mg == 1);
      chk("e_gnt", l, e_gnt_w[l], mg == 2);
      chk("sram_re", l, re_w[l], x_re);
      chk("sram_we", l, we_w[l], x_we);
      chk("sram_addr", l, addr_w[l], x_addr);
      chk("sram_wdata", l, wdata_w[l], x_wdata);
      chk("h_rvalid", l, h_rvalid_w[l], hv);
      chk("e_rvalid", l, e_rvalid_w[l], ev);
      chk("h_rdata", l, h_rdata_w[l], x_hrd[l]);
      chk("e_rdata", l, e_rdata_w[l], x_erd[l]);
      chk("busy", l, busy_w[l], bz);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic new_host();
    h_req = 1'b1; h_we = 1'($urandom); h_addr = 8'($urandom_range(0, 15)); h_wdata = 8'($urandom);
  endtask

  task automatic new_eng();
    e_req = 1'b1; e_addr = 8'($urandom_range(0, 15));
  endtask

  // Requesters hold until granted, then either issue a new access or drop.
  task automatic rand_drive(int ph, int pe);
    if (h_req && mg == 1) begin
      if ($urandom_range(0, 99) < 50) new_host(); else h_req = 1'b0;
    end else if (!h_req && $urandom_range(0, 99) < ph) new_host();
    if (e_req && mg == 2) begin
      if ($urandom_range(0, 99) < 60) new_eng(); else e_req = 1'b0;
    end else if (!e_req && $urandom_range(0, 99) < pe) new_eng();
  endtask

  initial begin
    string      pat;
    logic [7:0] c;
    logic [7:0] saved;
    n_chk = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    model_reset();
    reset = 1'b1; mem_clr = 1'b1;
    h_req = 1'b0; h_we = 1'b0; h_addr = 8'h00; h_wdata = 8'h00;
    e_req = 1'b1; e_addr = 8'h07;   // request during reset must not be acted on
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_all();
    mem_clr = 1'b0; reset = 1'b0; e_req = 1'b0;
    tick();

    // Host write 0x05 <= 0xA3, then read it back.
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h05; h_wdata = 8'hA3;
    tick();
    chk("wr_we", 0, we_w[0], 1'b1);
    chk("wr_addr", 0, addr_w[0], 8'h05);
    h_we = 1'b0;
    tick();
    chk("rd_re", 0, re_w[0], 1'b1);
    h_req = 1'b0;
    tick();
    chk("rd_rvalid", 0, h_rvalid_w[0], 1'b1);
    chk("rd_rdata", 0, h_rdata_w[0], 8'hA3);
    chk("rd_no_e", 0, e_rvalid_w[0], 1'b0);
    repeat (3) tick();

    // Seed 0x01..0x03, 0x10, 0x20 with known data.
    for (int a = 1; a <= 3; a++) begin
      h_req = 1'b1; h_we = 1'b1; h_addr = 8'(a); h_wdata = 8'(8'h30 + a);
      tick();
    end
    h_addr = 8'h10; h_wdata = 8'h5A; tick();
    h_addr = 8'h20; h_wdata = 8'hC3; tick();
    h_req = 1'b0; tick();

    // Engine sweep 3,2,1.
    e_req = 1'b1; e_addr = 8'h03; tick();
    chk("sweep_gnt", 0, e_gnt_w[0], 1'b1);
    e_addr = 8'h02; tick();
    e_addr = 8'h01; tick();
    e_req = 1'b0; tick();
    chk("sweep_last", 0, e_rdata_w[0], 8'h31);
    repeat (4) tick();
    chk("sweep_idle", 2, busy_w[2], 1'b0);

    // Contention: both held for 12 cycles.
    pat = "HHHHEHHHHEHH";
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h02;
    e_req = 1'b1; e_addr = 8'h03;
    for (int i = 0; i < 12; i++) begin
      tick();
      c = h_gnt_w[0] ? "H" : (e_gnt_w[0] ? "E" : "-");
      chk("pattern", 0, c, pat[i]);
      if (mg == 1) begin h_addr = 8'($urandom_range(0, 15)); h_we = 1'($urandom); end
      if (mg == 2) e_addr = 8'($urandom_range(0, 15));
    end
    h_req = 1'b0; e_req = 1'b0;
    repeat (4) tick();

    // Alternating host 0x10 / engine 0x20 reads.
    for (int r = 0; r < 4; r++) begin
      h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10;
      e_req = 1'b1; e_addr = 8'h20;
      tick();
      h_req = 1'b0;
      tick();
      e_req = 1'b0;
    end
    repeat (4) tick();
    chk("route_h", 2, h_rdata_w[2], 8'h5A);
    chk("route_e", 2, e_rdata_w[2], 8'hC3);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rand_drive(40, 40);
      tick();
    end
    h_req = 1'b0; e_req = 1'b0;
    repeat (4) tick();

    // Reset one cycle after an engine grant.
    e_req = 1'b1; e_addr = 8'h20; tick();
    e_req = 1'b0; tick();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    tick(); tick();
    reset = 1'b0;
    repeat (6) tick();

    // Idle hold after a host write.
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h44; h_wdata = 8'h99; tick();
    h_req = 1'b0;
    saved = x_addr;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_addr", 0, addr_w[0], saved);
      chk("idle_re", 0, re_w[0], 1'b0);
      chk("idle_we", 0, we_w[0], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
